// File: rtl/core_pkg.sv
// Shared core constants: datapath width, canonical NOP and base-ISA opcodes.
// No logic; imported by the fetch stage and the decoder.
// Fetch-stage sizing (buffer depth, discard counter width) also lives here.
package core_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   // addi x0, x0, 0
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OPCODE_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPCODE_STORE  = 7'b010_0011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b001_0011;
   localparam logic [6:0] OPCODE_OP     = 7'b011_0011;
   localparam logic [6:0] OPCODE_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPCODE_JAL    = 7'b110_1111;
   localparam logic [6:0] OPCODE_JALR   = 7'b110_0111;
   localparam logic [6:0] OPCODE_LUI    = 7'b011_0111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b001_0111;

   // Responses still owed by memory for flushed requests; headroom for
   // back-to-back redirects against a slow memory.
   localparam int DISCARD_W = 4;

endpackage

// File: rtl/core_if_stage_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Request side is valid/ready; responses are in order and cannot be stalled.
// master = fetch stage, slave = memory.
interface core_if_stage_if #(parameter int XLEN = core_pkg::XLEN);

   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] addr;
   logic            rsp_valid;
   logic [31:0]     rsp_data;

   modport master (output req_valid, addr, input req_ready, rsp_valid, rsp_data);
   modport slave  (input req_valid, addr, output req_ready, rsp_valid, rsp_data);

endinterface

// File: rtl/core_if_stage_fetch_buffer.sv
// Two-entry in-order fetch queue: allocate on request, fill on response, pop to decode.
// Latency: a response is visible at the head the cycle after it arrives.
// Backpressure: full blocks new allocations; flush clears entries and counts responses to drop.
module fetch_buffer
   import core_pkg::*;
#(
   parameter int XLEN = core_pkg::XLEN
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 alloc,
   input  logic [XLEN-1:0]      alloc_pc,
   input  logic                 rsp_vld,
   input  logic [ILEN-1:0]      rsp_dat,
   input  logic                 pop,
   output logic                 full,
   output logic                 head_vld,
   output logic [XLEN-1:0]      head_pc,
   output logic [ILEN-1:0]      head_instr,
   output logic [DISCARD_W-1:0] discard_cnt
);

   logic [XLEN-1:0]      pc_q    [2];
   logic [ILEN-1:0]      instr_q [2];
   logic                 head_q;
   logic [1:0]           cnt_q;
   logic [1:0]           nfill_q;
   logic [DISCARD_W-1:0] discard_q;

   // Filled entries always sit contiguously from the head, so counts replace per-entry flags.
   logic [1:0]           unfilled;
   logic                 rsp_drop;
   logic                 rsp_take;
   logic                 do_pop;
   logic                 fill_idx;
   logic                 alloc_idx;
   logic [DISCARD_W-1:0] pend;
   logic [DISCARD_W-1:0] flush_discard;

   assign unfilled  = cnt_q - nfill_q;
   assign rsp_drop  = rsp_vld && (discard_q != '0);
   assign rsp_take  = rsp_vld && (discard_q == '0) && (unfilled != 2'd0);
   assign do_pop    = pop && (nfill_q != 2'd0);
   assign fill_idx  = head_q ^ nfill_q[0];
   assign alloc_idx = head_q ^ cnt_q[0];

   // Everything still owed by memory after a flush; a response in the flush cycle is the oldest of them.
   assign pend          = discard_q + DISCARD_W'(unfilled);
   assign flush_discard = (rsp_vld && pend != '0) ? pend - 1'b1 : pend;

   assign full        = (cnt_q == 2'd2);
   assign head_vld    = (nfill_q != 2'd0);
   assign head_pc     = pc_q[head_q];
   assign head_instr  = instr_q[head_q];
   assign discard_cnt = discard_q;

   // Occupancy, fill level and discard bookkeeping; flush outranks every other update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q    <= 1'b0;
         cnt_q     <= 2'd0;
         nfill_q   <= 2'd0;
         discard_q <= '0;
      end else if (flush) begin
         head_q    <= 1'b0;
         cnt_q     <= 2'd0;
         nfill_q   <= 2'd0;
         discard_q <= flush_discard;
      end else begin
         if (rsp_drop) discard_q <= discard_q - 1'b1;
         if (do_pop)   head_q    <= ~head_q;
         cnt_q   <= cnt_q + {1'b0, alloc} - {1'b0, do_pop};
         nfill_q <= nfill_q + {1'b0, rsp_take} - {1'b0, do_pop};
      end
   end

   // Entry payload; validity is carried by the counters, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (alloc && !flush)    pc_q[alloc_idx]   <= alloc_pc;
      if (rsp_take && !flush) instr_q[fill_idx] <= rsp_dat;
   end

   // A response with nothing outstanding and nothing to discard is a memory protocol error.
   logic stray_rsp;
   assign stray_rsp = rsp_vld && (discard_q == '0) && (unfilled == 2'd0);
   assert property (@(posedge clk) disable iff (rst) !stray_rsp);

endmodule

// File: rtl/core_if_stage.sv
// Fetch stage: issues word-aligned PCs to imem and presents in-order instructions to decode.
// Latency: request accepted in N, 1-cycle memory -> valid_o in N+2; redirect in R -> new request in R+1.
// Backpressure: decode stall holds the head; issue stops when both buffer entries are allocated.
module core_if_stage
   import core_pkg::*;
#(
   parameter int              XLEN     = core_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                stall_i,
   input  logic                redirect_i,
   input  logic [XLEN-1:0]     redirect_pc_i,
   core_if_stage_if.master     imem,
   output logic                valid_o,
   output logic [ILEN-1:0]     instr_o,
   output logic [XLEN-1:0]     pc_o
);

   logic                 full;
   logic                 head_vld;
   logic [XLEN-1:0]      head_pc;
   logic [ILEN-1:0]      head_instr;
   logic                 accept;
   logic [XLEN-1:0]      fetch_pc_q;
   logic [XLEN-1:0]      redirect_target;
   logic [DISCARD_W-1:0] discard_cnt;

   // Issue looks only at registered occupancy, so a slot freed by a pop is reused the next cycle.
   assign imem.req_valid  = !full && !redirect_i && !rst_i;
   assign imem.addr       = fetch_pc_q;
   assign accept          = imem.req_valid && imem.req_ready;
   assign redirect_target = redirect_pc_i & ~XLEN'(3);

   // Next fetch address: redirect target wins, otherwise advance one word per accepted request.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)           fetch_pc_q <= RESET_PC;
      else if (redirect_i) fetch_pc_q <= redirect_target;
      else if (accept)     fetch_pc_q <= fetch_pc_q + XLEN'(4);
   end

   fetch_buffer #(.XLEN(XLEN)) u_buf (
      .clk         (clk_i),
      .rst         (rst_i),
      .flush       (redirect_i),
      .alloc       (accept),
      .alloc_pc    (fetch_pc_q),
      .rsp_vld     (imem.rsp_valid),
      .rsp_dat     (imem.rsp_data),
      .pop         (head_vld && !stall_i),
      .full        (full),
      .head_vld    (head_vld),
      .head_pc     (head_pc),
      .head_instr  (head_instr),
      .discard_cnt (discard_cnt)
   );

   assign valid_o = head_vld;
   assign instr_o = head_vld ? head_instr : NOP_INSTR;
   assign pc_o    = head_vld ? head_pc    : '0;

endmodule
